dma_apb_slave_regs: RTL
=======================

// Module: dma_apb_slave_regs
// PURPOSE
// APB completer holding the DMA channel control/status registers. Sits behind one
// select line of the DMA APB decoder/mux; returns pready/prdata/pslverr to it. Drives
// source/destination/length config and a start pulse to the DMA engine; captures
// engine busy/done status and raises an interrupt.
// PARAMETERS
// APB_ADDR_WIDTH  16  paddr width (byte address)
// APB_DATA_WIDTH  16  pwdata/prdata width; also width of every register
// WAIT_STATES     0   extra pready-low cycles inserted per access (0..15)
// PORTS
// i_clk         in   1    clock, all logic on rising edge
// i_rst_n       in   1    synchronous reset, active low
// i_psel        in   1    APB select for this completer
// i_penable     in   1    APB access phase
// i_pwrite      in   1    1 = write, 0 = read
// i_paddr       in   AW   byte address
// i_pwdata      in   DW   write data
// o_pready      out  1    transfer complete (registered)
// o_prdata      out  DW   read data, valid while o_pready=1 (registered)
// o_pslverr     out  1    error response, valid while o_pready=1 (registered)
// o_src_addr    out  DW   SRC register
// o_dst_addr    out  DW   DST register
// o_len         out  DW   LEN register
// o_start       out  1    one-cycle start pulse to DMA engine
// o_irq         out  1    STATUS.DONE & CTRL.IRQ_EN
// i_busy        in   1    engine busy (level)
// i_done        in   1    engine finished (one-cycle pulse)
// BEHAVIOUR
// Reset: all registers, o_pready, o_prdata, o_pslverr, o_start, o_irq = 0; FSM=IDLE.
// Reg index = i_paddr >> log2(DW/8); low byte-offset bits ignored.
//  0 SRC RW | 1 DST RW | 2 LEN RW | 3 CTRL: b0 START (W1, reads 0), b1 IRQ_EN RW
//  4 STATUS: b0 BUSY RO (=i_busy), b1 DONE sticky, W1C; other bits read 0.
//  index >4: pslverr=1, prdata=0, no state change.
// FSM IDLE -> WAIT when psel&penable (first access cycle); cnt <= WAIT_STATES.
// WAIT: cnt!=0 -> cnt--; cnt==0 -> RESP; at that edge o_pready<=1, o_prdata/o_pslverr
//   loaded from current reg values. psel=0 in WAIT -> IDLE, no response, no write.
// RESP: o_pready=1 for exactly one cycle; write committed at the edge ending RESP
//   (only if pslverr=0); next state IDLE, o_pready<=0.
// Access latency: pready high in access cycle WAIT_STATES+2 (min 2 cycles).
// Back-to-back: setup of next transfer may be the cycle after RESP; no bubble needed.
// START: write CTRL with b0=1 and i_busy=0 -> o_start=1 the cycle after RESP, once.
//   b0=1 while i_busy=1 -> pslverr=1, whole CTRL write dropped, no pulse.
// DONE: set by i_done; i_done and W1C in same cycle -> DONE stays 1 (set wins).
// o_irq combinational from DONE & IRQ_EN; reads never alter state.
// Reset asserted mid-transfer: immediately IDLE, outputs zero, pending write lost.
// TESTING
// Reset with psel=0: after release all outputs 0, reads of 0..4 return 0, pslverr=0.
// WAIT_STATES=0: write SRC=0x1234, read back -> pready high in 2nd access cycle, 0x1234.
// WAIT_STATES=3: read LEN -> pready low 4 access cycles, high on 5th for 1 cycle.
// Write CTRL=0x3, i_busy=0 -> o_start 1-cycle pulse, CTRL reads 0x2; repeat with
//  i_busy=1 -> pslverr=1, no pulse, CTRL unchanged.
// Pulse i_done with IRQ_EN=1 -> STATUS=0x2, o_irq=1; W1C 0x2 -> 0; W1C same cycle
//  as i_done -> DONE remains 1.
// Read index 7 -> pslverr=1, prdata=0; reset mid-WAIT of SRC write -> SRC unchanged.

Source files
------------

// File: rtl/dma_apb_slave_regs_if.sv
// APB bus bundle between the DMA APB decoder/mux (master side) and the
// DMA channel register completer (slave side).
interface dma_apb_slave_regs_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/dma_apb_slave_regs.sv
// DMA channel control/status registers behind an APB completer.
// Holds SRC/DST/LEN/CTRL, issues a one-cycle start pulse to the engine,
// tracks the sticky DONE flag and raises the interrupt.
module dma_apb_slave_regs #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 16,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    dma_apb_slave_regs_if.slave       apb,
    output logic [APB_DATA_WIDTH-1:0] o_src_addr,
    output logic [APB_DATA_WIDTH-1:0] o_dst_addr,
    output logic [APB_DATA_WIDTH-1:0] o_len,
    output logic                      o_start,
    output logic                      o_irq,
    input  logic                      i_busy,
    input  logic                      i_done
);
    localparam int AW    = APB_ADDR_WIDTH;
    localparam int DW    = APB_DATA_WIDTH;
    localparam int OFS_W = $clog2(DW / 8);
    // The first access cycle is spent in IDLE, so WAIT counts one less
    // than the requested number of extra cycles.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          pready_q;
    logic [DW-1:0] prdata_q;
    logic          pslverr_q;

    logic [DW-1:0] src_q, src_d;
    logic [DW-1:0] dst_q, dst_d;
    logic [DW-1:0] len_q, len_d;
    logic          irq_en_q, irq_en_d;
    logic          done_q, done_d;
    logic          start_q, start_d;

    logic [AW-1:0] idx;
    logic [2:0]    sel;
    logic          idx_ok;
    logic          err_now;
    logic          wr_fire;
    logic [DW-1:0] rd_data;

    assign idx    = apb.paddr >> OFS_W;
    assign idx_ok = (idx <= AW'(4));
    assign sel    = idx[2:0];

    // A START request while the engine is busy rejects the whole CTRL write.
    assign err_now = !idx_ok || (apb.pwrite && (sel == 3'd3) && apb.pwdata[0] && i_busy);

    // Register writes land on the edge that ends the response cycle.
    assign wr_fire = (state_q == S_RESP) && apb.psel && apb.pwrite && !pslverr_q && idx_ok;

    // Read mux over the current register values.
    always_comb begin
        rd_data = '0;
        if (idx_ok) begin
            case (sel)
                3'd0:    rd_data = src_q;
                3'd1:    rd_data = dst_q;
                3'd2:    rd_data = len_q;
                3'd3:    rd_data[1] = irq_en_q;
                3'd4:    begin
                             rd_data[0] = i_busy;
                             rd_data[1] = done_q;
                         end
                default: rd_data = '0;
            endcase
        end
    end

    // Next-state for the register file; a DONE pulse beats a same-cycle W1C.
    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        start_d  = 1'b0;
        if (wr_fire) begin
            case (sel)
                3'd0:    src_d = apb.pwdata;
                3'd1:    dst_d = apb.pwdata;
                3'd2:    len_d = apb.pwdata;
                3'd3:    begin
                             irq_en_d = apb.pwdata[1];
                             start_d  = apb.pwdata[0];
                         end
                3'd4:    if (apb.pwdata[1]) done_d = 1'b0;
                default: ;
            endcase
        end
        if (i_done) done_d = 1'b1;
    end

    // Register file state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            start_q  <= start_d;
        end
    end

    // APB access FSM with registered pready/prdata/pslverr.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (apb.psel && apb.penable) begin
                        if (WAIT_STATES == 0) begin
                            state_q   <= S_RESP;
                            pready_q  <= 1'b1;
                            prdata_q  <= rd_data;
                            pslverr_q <= err_now;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q   <= S_RESP;
                        pready_q  <= 1'b1;
                        prdata_q  <= rd_data;
                        pslverr_q <= err_now;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign o_src_addr  = src_q;
    assign o_dst_addr  = dst_q;
    assign o_len       = len_q;
    assign o_start     = start_q;
    assign o_irq       = done_q & irq_en_q;
endmodule
